// File: rtl/ps2_mouse_packet_decoder_pkg.sv
// Shared constants, packet bit positions and FSM encodings for the PS/2 mouse decoder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ps2_mouse_packet_decoder_pkg;

    // Default screen geometry and timing
    localparam int H_MAX_DEF          = 640;
    localparam int V_MAX_DEF          = 480;
    localparam int TIMEOUT_CYCLES_DEF = 2_000_000;
    localparam int EVENT_GAP_DEF      = 2048;

    // Bit positions inside the first (status) byte of a packet
    localparam int L_BIT    = 0;
    localparam int R_BIT    = 1;
    localparam int SYNC_BIT = 3;
    localparam int XS_BIT   = 4;
    localparam int YS_BIT   = 5;
    localparam int XOVF_BIT = 6;
    localparam int YOVF_BIT = 7;

    // Packet assembly states: one state per expected byte
    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2
    } pkt_state_t;

    // Status-byte fields kept while the rest of the packet arrives
    typedef struct packed {
        logic yovf;
        logic xovf;
        logic ys;
        logic xs;
        logic right;
        logic left;
    } pkt_hdr_t;

    function automatic pkt_hdr_t decode_hdr(input logic [7:0] b);
        pkt_hdr_t h;
        h.yovf  = b[YOVF_BIT];
        h.xovf  = b[XOVF_BIT];
        h.ys    = b[YS_BIT];
        h.xs    = b[XS_BIT];
        h.right = b[R_BIT];
        h.left  = b[L_BIT];
        return h;
    endfunction

endpackage

// File: rtl/ps2_mouse_packet_decoder_if.sv
// Byte stream in, published cursor state out, bundled for the decoder.
// Latency: none (wires only).
// Backpressure: none; the byte stream is a strobe with no ready path.
interface ps2_mouse_packet_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] MOUSE_X_POS;
    logic [9:0] MOUSE_Y_POS;
    logic       MOUSE_LEFT;
    logic       MOUSE_RIGHT;
    logic       new_event;
    logic       resync_drop;

    // Byte source / event consumer side
    modport master (
        output rx_data, rx_valid,
        input  MOUSE_X_POS, MOUSE_Y_POS, MOUSE_LEFT, MOUSE_RIGHT, new_event, resync_drop
    );

    // Decoder side
    modport slave (
        input  rx_data, rx_valid,
        output MOUSE_X_POS, MOUSE_Y_POS, MOUSE_LEFT, MOUSE_RIGHT, new_event, resync_drop
    );
endinterface

// File: rtl/ps2_mouse_packet_decoder_axis_accum_clamp.sv
// One cursor axis: position plus signed 9-bit delta, clamped to 0..max.
// Latency: combinational.
// Backpressure: none.
module axis_accum_clamp (
    input  logic [9:0]        pos,
    input  logic signed [8:0] delta,
    input  logic              ovf,     // overflowed delta is ignored
    input  logic              invert,  // subtract instead of add (PS/2 Y grows upward)
    input  logic [9:0]        max,     // largest legal position, inclusive
    output logic [9:0]        next_pos
);

    logic signed [10:0] pos_s;
    logic signed [10:0] delta_s;
    logic signed [10:0] lim_s;
    logic signed [10:0] sum;

    // 11-bit signed add covers -256..895, so both clamp ends are visible
    always_comb begin
        pos_s    = $signed({1'b0, pos});
        lim_s    = $signed({1'b0, max});
        delta_s  = ovf ? 11'sd0 : $signed({{2{delta[8]}}, delta});
        if (invert) begin
            delta_s = -delta_s;
        end
        sum      = pos_s + delta_s;
        next_pos = sum[9:0];
        if (sum < 11'sd0) begin
            next_pos = '0;
        end else if (sum > lim_s) begin
            next_pos = max;
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets into a clamped cursor and publishes rate-limited events.
// Latency: new_event two cycles after the byte2 strobe when no event gap is running.
// Backpressure: none upstream; downstream is protected by a minimum gap with coalescing of packets.
module ps2_mouse_packet_decoder
    import ps2_mouse_packet_decoder_pkg::*;
#(
    parameter int H_MAX          = H_MAX_DEF,
    parameter int V_MAX          = V_MAX_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int EVENT_GAP      = EVENT_GAP_DEF
) (
    input logic                        clk,
    input logic                        rst,
    ps2_mouse_packet_decoder_if.slave  bus
);

    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (EVENT_GAP > 2) ? $clog2(EVENT_GAP) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(EVENT_GAP - 1);
    localparam logic [9:0]       X_LIM    = 10'(H_MAX - 1);
    localparam logic [9:0]       Y_LIM    = 10'(V_MAX - 1);
    localparam logic [9:0]       X_HOME   = 10'(H_MAX / 2);
    localparam logic [9:0]       Y_HOME   = 10'(V_MAX / 2);

    pkt_state_t        state_q, state_d;
    pkt_hdr_t          hdr_q;
    logic [7:0]        dx_lo_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [GAP_W-1:0]  gap_q;
    logic              pending_q;

    logic [9:0]        acc_x_q, acc_y_q;
    logic              acc_l_q, acc_r_q;
    logic [9:0]        pub_x_q, pub_y_q;
    logic              pub_l_q, pub_r_q;
    logic              new_event_q;
    logic              drop_q;

    logic              hdr_ld, dx_ld, complete, bad_sync, timeout, publish;
    logic signed [8:0] dx, dy;
    logic [9:0]        next_x, next_y;

    // Byte2 is consumed straight off the bus in its strobe cycle
    assign dx = $signed({hdr_q.xs, dx_lo_q});
    assign dy = $signed({hdr_q.ys, bus.rx_data});

    axis_accum_clamp u_x (
        .pos      (acc_x_q),
        .delta    (dx),
        .ovf      (hdr_q.xovf),
        .invert   (1'b0),
        .max      (X_LIM),
        .next_pos (next_x)
    );

    axis_accum_clamp u_y (
        .pos      (acc_y_q),
        .delta    (dy),
        .ovf      (hdr_q.yovf),
        .invert   (1'b1),
        .max      (Y_LIM),
        .next_pos (next_y)
    );

    // Packet FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BYTE0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-byte strobes; a byte arriving on the last idle cycle still wins over timeout
    always_comb begin
        state_d  = state_q;
        hdr_ld   = 1'b0;
        dx_ld    = 1'b0;
        complete = 1'b0;
        bad_sync = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            BYTE0: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data[SYNC_BIT]) begin
                        hdr_ld  = 1'b1;
                        state_d = BYTE1;
                    end else begin
                        bad_sync = 1'b1;
                    end
                end
            end
            BYTE1: begin
                if (bus.rx_valid) begin
                    dx_ld   = 1'b1;
                    state_d = BYTE2;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = BYTE0;
                end
            end
            BYTE2: begin
                if (bus.rx_valid) begin
                    complete = 1'b1;
                    state_d  = BYTE0;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = BYTE0;
                end
            end
            default: begin
                state_d = BYTE0;
            end
        endcase
        publish = pending_q && (gap_q == '0);
    end

    // Packet field capture and mid-packet idle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q    <= '0;
            dx_lo_q  <= '0;
            to_cnt_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (hdr_ld) begin
                hdr_q <= decode_hdr(bus.rx_data);
            end
            if (dx_ld) begin
                dx_lo_q <= bus.rx_data;
            end
            if (state_q == BYTE0 || bus.rx_valid || timeout) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            drop_q <= bad_sync | timeout;
        end
    end

    // Accumulated cursor keeps moving even while events are held off
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_x_q <= X_HOME;
            acc_y_q <= Y_HOME;
            acc_l_q <= 1'b0;
            acc_r_q <= 1'b0;
        end else if (complete) begin
            acc_x_q <= next_x;
            acc_y_q <= next_y;
            acc_l_q <= hdr_q.left;
            acc_r_q <= hdr_q.right;
        end
    end

    // Event gap and publish; a completion on a publish edge re-arms pending for the next window
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q       <= '0;
            pending_q   <= 1'b0;
            new_event_q <= 1'b0;
            pub_x_q     <= X_HOME;
            pub_y_q     <= Y_HOME;
            pub_l_q     <= 1'b0;
            pub_r_q     <= 1'b0;
        end else begin
            new_event_q <= publish;
            if (publish) begin
                pub_x_q   <= acc_x_q;
                pub_y_q   <= acc_y_q;
                pub_l_q   <= acc_l_q;
                pub_r_q   <= acc_r_q;
                gap_q     <= GAP_LOAD;
                pending_q <= 1'b0;
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
            if (complete) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign bus.MOUSE_X_POS = pub_x_q;
    assign bus.MOUSE_Y_POS = pub_y_q;
    assign bus.MOUSE_LEFT  = pub_l_q;
    assign bus.MOUSE_RIGHT = pub_r_q;
    assign bus.new_event   = new_event_q;
    assign bus.resync_drop = drop_q;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Directed bench for the PS/2 packet decoder with shortened timeout and event gap.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_mouse_packet_decoder;

    localparam int TO  = 64;
    localparam int GAP = 32;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    int         ev_cnt = 0;
    logic [9:0] ev_x [0:31];

    ps2_mouse_packet_decoder_if bus ();

    ps2_mouse_packet_decoder #(
        .H_MAX          (640),
        .V_MAX          (480),
        .TIMEOUT_CYCLES (TO),
        .EVENT_GAP      (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Event log sampled away from the active edge
    always @(negedge clk) begin
        if (bus.new_event) begin
            ev_x[ev_cnt[4:0]] <= bus.MOUSE_X_POS;
            ev_cnt            <= ev_cnt + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Bounded wait for the next new_event pulse
    task automatic wait_event(input string tag, input int budget);
        int found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.new_event) begin
                found = 1;
                break;
            end
        end
        check(tag, found, 1);
    endtask

    initial begin
        int base;
        int n;

        rst          = 1'b1;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        do_reset();

        // Reset state
        check("rst_x",     bus.MOUSE_X_POS, 320);
        check("rst_y",     bus.MOUSE_Y_POS, 240);
        check("rst_left",  bus.MOUSE_LEFT,  0);
        check("rst_right", bus.MOUSE_RIGHT, 0);
        check("rst_event", bus.new_event,   0);
        check("rst_drop",  bus.resync_drop, 0);

        // 1: basic packet, latency 2
        send(8'h09); send(8'h05); send(8'h03);
        check("t1_lat1", bus.new_event, 0);
        @(negedge clk);
        check("t1_lat2",  bus.new_event,   1);
        check("t1_x",     bus.MOUSE_X_POS, 325);
        check("t1_y",     bus.MOUSE_Y_POS, 237);
        check("t1_left",  bus.MOUSE_LEFT,  1);
        check("t1_right", bus.MOUSE_RIGHT, 0);
        @(negedge clk);
        check("t1_pulse", bus.new_event, 0);

        // 2: negative X delta, then clamp at 0
        do_reset();
        send(8'h18); send(8'h00); send(8'h00);
        wait_event("t2_ev1", 10);
        check("t2_x1", bus.MOUSE_X_POS, 64);
        check("t2_y1", bus.MOUSE_Y_POS, 240);
        repeat (GAP + 8) @(negedge clk);
        send(8'h18); send(8'h00); send(8'h00);
        wait_event("t2_ev2", 10);
        check("t2_x2", bus.MOUSE_X_POS, 0);
        check("t2_y2", bus.MOUSE_Y_POS, 240);

        // 3: bad sync byte dropped, FSM stays in BYTE0
        do_reset();
        send(8'h02);
        check("t3_drop", bus.resync_drop, 1);
        @(negedge clk);
        check("t3_drop_pulse", bus.resync_drop, 0);
        send(8'h0A); send(8'h01); send(8'h01);
        wait_event("t3_ev", 10);
        check("t3_right", bus.MOUSE_RIGHT, 1);
        check("t3_left",  bus.MOUSE_LEFT,  0);
        check("t3_x",     bus.MOUSE_X_POS, 321);
        check("t3_y",     bus.MOUSE_Y_POS, 239);

        // 4: partial packet times out after exactly TO idle cycles
        do_reset();
        send(8'h08); send(8'h10);
        n = 0;
        for (int i = 1; i <= TO + 20; i++) begin
            @(negedge clk);
            if (bus.resync_drop) begin
                n = i;
                break;
            end
        end
        check("t4_timeout_cycles", n, TO);
        send(8'h09); send(8'h01); send(8'h00);
        wait_event("t4_ev", 10);
        check("t4_x",    bus.MOUSE_X_POS, 321);
        check("t4_y",    bus.MOUSE_Y_POS, 240);
        check("t4_left", bus.MOUSE_LEFT,  1);

        // 5: back-to-back packets coalesce into one deferred event
        do_reset();
        base = ev_cnt;
        for (int p = 0; p < 3; p++) begin
            send(8'h08); send(8'h01); send(8'h00);
        end
        check("t5_hold_x",    bus.MOUSE_X_POS, 321);
        check("t5_ev_early",  ev_cnt - base, 1);
        repeat (3 * GAP) @(negedge clk);
        check("t5_ev_total",  ev_cnt - base, 2);
        check("t5_ev1_x",     ev_x[base[4:0]], 321);
        check("t5_ev2_x",     ev_x[5'(base + 1)], 323);

        // 6: overflowed X ignored, then reset mid-packet and mid-gap
        do_reset();
        send(8'h09); send(8'h05); send(8'h03);
        wait_event("t6_ev1", 10);
        repeat (GAP + 8) @(negedge clk);
        send(8'h48); send(8'hFF); send(8'h00);
        wait_event("t6_ev2", 10);
        check("t6_ovf_x",    bus.MOUSE_X_POS, 325);
        check("t6_ovf_y",    bus.MOUSE_Y_POS, 237);
        check("t6_ovf_left", bus.MOUSE_LEFT,  0);
        send(8'h09); send(8'h05);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base = ev_cnt;
        check("t6_rst_x",    bus.MOUSE_X_POS, 320);
        check("t6_rst_y",    bus.MOUSE_Y_POS, 240);
        check("t6_rst_left", bus.MOUSE_LEFT,  0);
        repeat (10) @(negedge clk);
        check("t6_no_event", ev_cnt - base, 0);
        send(8'h03);
        check("t6_byte0_drop", bus.resync_drop, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
